// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator: default counter width and the
// resulting period length in clocks.
package pwm_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int PWM_PERIOD    = 2 ** CNT_W_DEFAULT;

endpackage

// File: rtl/pwm_generator_if.sv
// Timebase bus between the period counter and the duty/compare stage:
// the running count plus a one-cycle terminal-count strobe.
interface pwm_generator_if #(
  parameter int CNT_W = pwm_pkg::CNT_W_DEFAULT
);

  logic [CNT_W-1:0] cnt;
  logic             tc;

  modport master (output cnt, output tc);
  modport slave  (input cnt, input tc);

endinterface

// File: rtl/pwm_period_counter.sv
// Free-running period counter; wraps naturally at 2^CNT_W and flags the
// last count of each period so the duty register can reload there.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  pwm_generator_if.master bus
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.cnt = cnt;
  assign bus.tc  = (cnt == {CNT_W{1'b1}});

endmodule

// File: rtl/pwm_generator.sv
// Registered PWM: the duty value is captured only at the period boundary, so
// a period already in progress always finishes with its original duty.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] PWM_ontime,
  output logic             PWM_out
);

  pwm_generator_if #(.CNT_W(CNT_W)) cnt_bus ();

  pwm_period_counter #(.CNT_W(CNT_W)) u_period_counter (
    .clk   (clk),
    .reset (reset),
    .bus   (cnt_bus.master)
  );

  logic [CNT_W-1:0] duty_act;
  logic             pwm_next;

  // Compare against the held duty only; PWM_ontime never reaches the output path.
  assign pwm_next = (cnt_bus.cnt < duty_act);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_act <= '0;
      PWM_out  <= 1'b0;
    end else begin
      if (cnt_bus.tc) begin
        duty_act <= PWM_ontime;
      end
      PWM_out <= pwm_next;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed and table-driven checks of pwm_generator: reset behaviour, per-period
// high/low counts, duty reload timing and a per-clock check on random duties.
module tb_pwm_generator;
  import pwm_pkg::*;

  localparam int W = CNT_W_DEFAULT;
  localparam int P = PWM_PERIOD;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] pwm_ontime = '0;
  logic         pwm_out;

  pwm_generator #(.CNT_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .PWM_ontime (pwm_ontime),
    .PWM_out    (pwm_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct {
    logic [7:0] ontime;
    int         exp_hi;
    int         exp_lo;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // 20 ns reset pulse released on a falling edge; edge_n counts edges after release.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_out", int'(pwm_out), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
  endtask

  // One aligned period: count high clocks and samples deviating from the ideal shape.
  task automatic measure_period(input int d_exp, output int hi, output int shape_err);
    hi = 0;
    shape_err = 0;
    for (int r = 0; r < P; r++) begin
      tick();
      if (pwm_out) hi++;
      if (int'(pwm_out) != ((r < d_exp) ? 1 : 0)) shape_err++;
    end
  endtask

  initial begin
    int hi;
    int se;
    int tot;
    int cur_duty;
    int r;
    int expv;
    int mism;

    vecs[0] = '{8'd0,   0,   256};
    vecs[1] = '{8'd200, 200, 56};
    vecs[2] = '{8'd255, 255, 1};
    vecs[3] = '{8'd1,   1,   255};
    vecs[4] = '{8'd128, 128, 128};
    vecs[5] = '{8'd37,  37,  219};

    // Asynchronous reset with no clock edge involved
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_initial", int'(pwm_out), 0);
    #17;
    reset = 1'b0;

    // Scenario 1: duty 0 stays low for three periods
    apply_reset();
    pwm_ontime = 8'd0;
    tot = 0;
    for (int p = 0; p < 3; p++) begin
      measure_period(0, hi, se);
      tot += hi;
    end
    check("zero_duty_hi_3periods", tot, 0);
    $display("scenario zero duty: high clocks over 3 periods=%0d", tot);

    // Table: first period low, second period shows the requested duty
    foreach (vecs[i]) begin
      apply_reset();
      pwm_ontime = vecs[i].ontime;
      measure_period(0, hi, se);
      check("first_period_hi", hi, 0);
      measure_period(vecs[i].exp_hi, hi, se);
      check("period_hi", hi, vecs[i].exp_hi);
      check("period_lo", P - hi, vecs[i].exp_lo);
      check("period_shape", se, 0);
      $display("vector ontime=%0d high=%0d low=%0d shape_errs=%0d",
               vecs[i].ontime, hi, P - hi, se);
    end

    // Scenario 4: mid-period change is deferred to the next period
    apply_reset();
    pwm_ontime = 8'd100;
    measure_period(0, hi, se);
    hi = 0;
    for (int k = 0; k < P; k++) begin
      tick();
      if (pwm_out) hi++;
      if (k == 30) pwm_ontime = 8'd50;
    end
    check("midchange_current_hi", hi, 100);
    measure_period(50, hi, se);
    check("midchange_next_hi", hi, 50);
    check("midchange_next_shape", se, 0);
    $display("scenario mid-period change: next period high=%0d", hi);

    // Scenario 5: two back-to-back resets while the output is high
    pwm_ontime = 8'd200;
    apply_reset();
    measure_period(0, hi, se);
    for (int k = 0; k < 10; k++) tick();
    check("pre_reset_out_high", int'(pwm_out), 1);
    reset = 1'b1;
    #2;
    check("async_reset_pulse1", int'(pwm_out), 0);
    #18;
    reset = 1'b0;
    #20;
    reset = 1'b1;
    #2;
    check("async_reset_pulse2", int'(pwm_out), 0);
    #18;
    reset = 1'b0;
    edge_n = 0;
    measure_period(0, hi, se);
    check("post_reset_first_hi", hi, 0);
    measure_period(200, hi, se);
    check("post_reset_hi", hi, 200);
    check("post_reset_shape", se, 0);
    $display("scenario double reset: post-release period high=%0d", hi);

    // Scenario 6: random duties, each held for two periods, checked every clock
    apply_reset();
    cur_duty = 0;
    for (int i = 0; i < 10; i++) begin
      pwm_ontime = W'($urandom_range(0, P - 1));
      mism = failures;
      for (int k = 0; k < 2 * P; k++) begin
        r = edge_n % P;
        expv = (r < cur_duty) ? 1 : 0;
        tick();
        check("random_clk", int'(pwm_out), expv);
        if (r == P - 1) cur_duty = int'(pwm_ontime);
      end
      $display("random duty=%0d errors=%0d", pwm_ontime, failures - mism);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
